// File: rtl/reorder_buffer.sv
// In-order retirement buffer: two allocation slots, NUM_FU writeback ports, registered retire.
// Define ROB_DUAL_RETIRE_EN for two retire slots per cycle; otherwise only slot 0 retires.
module reorder_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NUM_FU = 3,
    localparam int unsigned IdxW  = $clog2(DEPTH),
    localparam int unsigned RowW  = IdxW + 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    // Row layout, MSB first: valid, ROBNumber, PRegAddrDst[5:0], OldPRegAddrDst[5:0],
    // RegWrite, MemWrite, MemtoReg.
    input  logic [RowW-1:0] i_rob_rows        [0:1],
    input  logic            i_cmpl_valid      [0:NUM_FU-1],
    input  logic [IdxW-1:0] i_cmpl_rob        [0:NUM_FU-1],
    input  logic [31:0]     i_cmpl_data       [0:NUM_FU-1],
    output logic            o_retire_valid    [0:1],
    output logic [5:0]      o_retire_dst      [0:1],
    output logic [31:0]     o_retire_data     [0:1],
    output logic            o_retire_regwrite [0:1],
    output logic            o_retire_memwrite [0:1],
    output logic [5:0]      o_free_preg       [0:1],
    output logic [IdxW-1:0] o_head,
    output logic [IdxW:0]   o_count,
    output logic            o_err
);

    localparam int unsigned CntW = IdxW + 1;

    logic [DEPTH-1:0] valid_q, valid_d, cmpl_q, cmpl_d;
    logic [DEPTH-1:0] rw_q, rw_d, mw_q, mw_d, m2r_q, m2r_d;
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [5:0]       dst_q  [DEPTH];
    logic [5:0]       dst_d  [DEPTH];
    logic [5:0]       old_q  [DEPTH];
    logic [5:0]       old_d  [DEPTH];

    logic [IdxW-1:0]  head_q, head_d, head1, idx;
    logic [CntW-1:0]  count_q, count_d;
    logic             err_q, err_d;
    logic             ret0, ret1;
    logic [DEPTH-1:0] alloc_hit, cmpl_hit;

    logic             rv_q    [0:1];
    logic             rv_d    [0:1];
    logic [5:0]       rdst_q  [0:1];
    logic [5:0]       rdst_d  [0:1];
    logic [31:0]      rdata_q [0:1];
    logic [31:0]      rdata_d [0:1];
    logic             rrw_q   [0:1];
    logic             rrw_d   [0:1];
    logic             rmw_q   [0:1];
    logic             rmw_d   [0:1];
    logic [5:0]       rfree_q [0:1];
    logic [5:0]       rfree_d [0:1];

    always_comb begin
        valid_d   = valid_q;
        cmpl_d    = cmpl_q;
        data_d    = data_q;
        dst_d     = dst_q;
        old_d     = old_q;
        rw_d      = rw_q;
        mw_d      = mw_q;
        m2r_d     = m2r_q;
        err_d     = err_q;
        alloc_hit = '0;
        cmpl_hit  = '0;
        idx       = '0;
        count_d   = '0;
        head1     = head_q + IdxW'(1);

        ret0 = valid_q[head_q] & cmpl_q[head_q];
`ifdef ROB_DUAL_RETIRE_EN
        ret1 = ret0 & valid_q[head1] & cmpl_q[head1];
`else
        ret1 = 1'b0;
`endif

        for (int s = 0; s < 2; s++) begin
            rv_d[s]    = 1'b0;
            rdst_d[s]  = '0;
            rdata_d[s] = '0;
            rrw_d[s]   = 1'b0;
            rmw_d[s]   = 1'b0;
            rfree_d[s] = '0;
        end

        if (ret0) begin
            rv_d[0]         = 1'b1;
            rdst_d[0]       = dst_q[head_q];
            rdata_d[0]      = data_q[head_q];
            rrw_d[0]        = rw_q[head_q];
            rmw_d[0]        = mw_q[head_q];
            rfree_d[0]      = old_q[head_q];
            valid_d[head_q] = 1'b0;
            cmpl_d[head_q]  = 1'b0;
        end
        if (ret1) begin
            rv_d[1]        = 1'b1;
            rdst_d[1]      = dst_q[head1];
            rdata_d[1]     = data_q[head1];
            rrw_d[1]       = rw_q[head1];
            rmw_d[1]       = mw_q[head1];
            rfree_d[1]     = old_q[head1];
            valid_d[head1] = 1'b0;
            cmpl_d[head1]  = 1'b0;
        end

        // Retire clears before allocation, so reuse of a retiring index is legal; slot 0
        // marks its entry valid first, which makes a duplicate slot-1 index an overwrite.
        for (int s = 0; s < 2; s++) begin
            if (i_rob_rows[s][RowW-1]) begin
                idx = i_rob_rows[s][RowW-2 -: IdxW];
                if (valid_d[idx]) err_d = 1'b1;
                valid_d[idx]   = 1'b1;
                cmpl_d[idx]    = 1'b0;
                dst_d[idx]     = i_rob_rows[s][14:9];
                old_d[idx]     = i_rob_rows[s][8:3];
                rw_d[idx]      = i_rob_rows[s][2];
                mw_d[idx]      = i_rob_rows[s][1];
                m2r_d[idx]     = i_rob_rows[s][0];
                alloc_hit[idx] = 1'b1;
            end
        end

        // Ascending FU order: the first writeback to an index claims it.
        for (int f = 0; f < NUM_FU; f++) begin
            if (i_cmpl_valid[f]) begin
                idx = i_cmpl_rob[f];
                if (!(valid_q[idx] || alloc_hit[idx])) begin
                    err_d = 1'b1;
                end else if (cmpl_hit[idx]) begin
                    err_d = 1'b1;
                end else if (valid_d[idx]) begin
                    cmpl_d[idx] = 1'b1;
                    data_d[idx] = i_cmpl_data[f];
                end
                cmpl_hit[idx] = 1'b1;
            end
        end

        head_d = head_q + IdxW'(ret0) + IdxW'(ret1);
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CntW'(valid_d[i]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            cmpl_q  <= '0;
            rw_q    <= '0;
            mw_q    <= '0;
            m2r_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                dst_q[i]  <= '0;
                old_q[i]  <= '0;
            end
            head_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                rv_q[s]    <= 1'b0;
                rdst_q[s]  <= '0;
                rdata_q[s] <= '0;
                rrw_q[s]   <= 1'b0;
                rmw_q[s]   <= 1'b0;
                rfree_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cmpl_q  <= cmpl_d;
            rw_q    <= rw_d;
            mw_q    <= mw_d;
            m2r_q   <= m2r_d;
            data_q  <= data_d;
            dst_q   <= dst_d;
            old_q   <= old_d;
            head_q  <= head_d;
            count_q <= count_d;
            err_q   <= err_d;
            rv_q    <= rv_d;
            rdst_q  <= rdst_d;
            rdata_q <= rdata_d;
            rrw_q   <= rrw_d;
            rmw_q   <= rmw_d;
            rfree_q <= rfree_d;
        end
    end

    assign o_retire_valid    = rv_q;
    assign o_retire_dst      = rdst_q;
    assign o_retire_data     = rdata_q;
    assign o_retire_regwrite = rrw_q;
    assign o_retire_memwrite = rmw_q;
    assign o_free_preg       = rfree_q;
    assign o_head            = head_q;
    assign o_count           = count_q;
    assign o_err             = err_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: scoreboard of expected retires in ROB order.
// Honours ROB_DUAL_RETIRE_EN the same way as the design.
module tb_reorder_buffer;

    typedef struct {
        logic [5:0]  dst;
        logic [5:0]  old;
        logic [31:0] data;
        logic        rw;
        logic        mw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] rob_rows [0:1];
    logic        cmpl_valid [0:2];
    logic [3:0]  cmpl_rob [0:2];
    logic [31:0] cmpl_data [0:2];
    logic        retire_valid [0:1];
    logic [5:0]  retire_dst [0:1];
    logic [31:0] retire_data [0:1];
    logic        retire_regwrite [0:1];
    logic        retire_memwrite [0:1];
    logic [5:0]  free_preg [0:1];
    logic [3:0]  head;
    logic [4:0]  count;
    logic        err;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.DEPTH(16), .NUM_FU(3)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_rob_rows        (rob_rows),
        .i_cmpl_valid      (cmpl_valid),
        .i_cmpl_rob        (cmpl_rob),
        .i_cmpl_data       (cmpl_data),
        .o_retire_valid    (retire_valid),
        .o_retire_dst      (retire_dst),
        .o_retire_data     (retire_data),
        .o_retire_regwrite (retire_regwrite),
        .o_retire_memwrite (retire_memwrite),
        .o_free_preg       (free_preg),
        .o_head            (head),
        .o_count           (count),
        .o_err             (err)
    );

    task automatic idle();
        for (int s = 0; s < 2; s++) rob_rows[s] = '0;
        for (int f = 0; f < 3; f++) begin
            cmpl_valid[f] = 1'b0;
            cmpl_rob[f]   = '0;
            cmpl_data[f]  = '0;
        end
    endtask

    task automatic set_alloc(input int s, input logic [3:0] rob, input logic [5:0] dst,
                             input logic [5:0] old, input logic rw, input logic mw,
                             input logic [31:0] data, input bit push);
        exp_t e;
        rob_rows[s] = {1'b1, rob, dst, old, rw, mw, 1'b1};
        if (push) begin
            e.dst = dst; e.old = old; e.data = data; e.rw = rw; e.mw = mw;
            exp_q.push_back(e);
        end
    endtask

    task automatic set_cmpl(input int f, input logic [3:0] rob, input logic [31:0] data);
        cmpl_valid[f] = 1'b1;
        cmpl_rob[f]   = rob;
        cmpl_data[f]  = data;
    endtask

    // One clock; retire outputs are checked against the scoreboard on the falling edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (retire_valid[s] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_retire slot%0d: got dst=%0d data=%h, required no retire",
                             s, retire_dst[s], retire_data[s]);
                end else begin
                    e = exp_q.pop_front();
                    if (retire_dst[s] !== e.dst || free_preg[s] !== e.old ||
                        retire_data[s] !== e.data || retire_regwrite[s] !== e.rw ||
                        retire_memwrite[s] !== e.mw) begin
                        n_fail++;
                        $display("FAIL retire_fields slot%0d: got dst=%0d free=%0d data=%h rw=%b mw=%b, required dst=%0d free=%0d data=%h rw=%b mw=%b",
                                 s, retire_dst[s], free_preg[s], retire_data[s], retire_regwrite[s],
                                 retire_memwrite[s], e.dst, e.old, e.data, e.rw, e.mw);
                    end
                end
            end else if (retire_valid[s] !== 1'b0 || retire_dst[s] !== 6'd0 ||
                         free_preg[s] !== 6'd0 || retire_data[s] !== 32'd0 ||
                         retire_regwrite[s] !== 1'b0 || retire_memwrite[s] !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_outputs slot%0d: got valid=%b dst=%0d data=%h, required all 0",
                         s, retire_valid[s], retire_dst[s], retire_data[s]);
            end
        end
        n_checks++;
        if (retire_valid[1] === 1'b1 && retire_valid[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL slot1_without_slot0: got valid0=%b valid1=1, required valid0=1",
                     retire_valid[0]);
        end
`ifndef ROB_DUAL_RETIRE_EN
        n_checks++;
        if (retire_valid[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_build_slot1: got %b, required 0", retire_valid[1]);
        end
`endif
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d retires pending after %0d cycles, required 0",
                     exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (head !== 4'd0 || count !== 5'd0 || err !== 1'b0 || retire_valid[0] !== 1'b0 ||
            retire_valid[1] !== 1'b0 || retire_data[0] !== 32'd0 || free_preg[0] !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_state: got head=%0d count=%0d err=%b rv0=%b rv1=%b, required all 0",
                     head, count, err, retire_valid[0], retire_valid[1]);
        end
        rst_n = 1'b1;
        set_alloc(0, 4'd0, 6'd5, 6'd3, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
        set_cmpl(0, 4'd0, 32'hDEADBEEF);
        tick();
        idle();
        n_checks++;
        if (retire_valid[0] !== 1'b0 || count !== 5'd1) begin
            n_fail++;
            $display("FAIL first_edge: got rv0=%b count=%0d, required rv0=0 count=1",
                     retire_valid[0], count);
        end
        tick();
        n_checks++;
        if (retire_valid[0] !== 1'b1 || head !== 4'd1 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL first_retire: got rv0=%b head=%0d count=%0d, required 1 1 0",
                     retire_valid[0], head, count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_alloc(0, 4'd0, 6'd9, 6'd8, 1'b1, 1'b1, 32'h1234, 1'b0);
        set_cmpl(0, 4'd0, 32'h1234);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (count !== 5'd0 || head !== 4'd0 || retire_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got count=%0d head=%0d rv0=%b, required 0 0 0",
                     count, head, retire_valid[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (head !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_discard_head: got %0d, required 0", head);
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        set_alloc(0, 4'd0, 6'd10, 6'd20, 1'b1, 1'b0, 32'hA0, 1'b1);
        set_alloc(1, 4'd1, 6'd11, 6'd21, 1'b0, 1'b1, 32'hA1, 1'b1);
        tick(); idle();
        set_alloc(0, 4'd2, 6'd12, 6'd22, 1'b1, 1'b1, 32'hA2, 1'b1);
        tick(); idle();
        set_cmpl(2, 4'd2, 32'hA2);
        tick(); idle();
        set_cmpl(1, 4'd1, 32'hA1);
        tick(); idle();
        tick();
        n_checks++;
        if (retire_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ooo_hold: got rv0=%b, required 0", retire_valid[0]);
        end
        set_cmpl(0, 4'd0, 32'hA0);
        tick(); idle();
        tick();
        n_checks++;
`ifdef ROB_DUAL_RETIRE_EN
        if (retire_valid[0] !== 1'b1 || retire_valid[1] !== 1'b1) begin
`else
        if (retire_valid[0] !== 1'b1 || retire_valid[1] !== 1'b0) begin
`endif
            n_fail++;
            $display("FAIL ooo_release: got rv0=%b rv1=%b", retire_valid[0], retire_valid[1]);
        end
        drain(4);
        n_checks++;
        if (head !== 4'd3 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL ooo_head: got head=%0d count=%0d, required 3 0", head, count);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] r;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            for (int s = 0; s < 2; s++) begin
                r = 4'(2 * k + s);
                set_alloc(s, r, 6'(r), 6'(r + 32), 1'b1, 1'b0, 32'hB000 + 32'(r), 1'b1);
                set_cmpl(s, r, 32'hB000 + 32'(r));
            end
            tick(); idle();
        end
        drain(20);
        n_checks++;
        if (head !== 4'd14) begin
            n_fail++;
            $display("FAIL wrap_setup_head: got %0d, required 14", head);
        end
        set_alloc(0, 4'd14, 6'd40, 6'd50, 1'b1, 1'b0, 32'hC00E, 1'b1);
        set_alloc(1, 4'd15, 6'd41, 6'd51, 1'b0, 1'b1, 32'hC00F, 1'b1);
        tick(); idle();
        set_alloc(0, 4'd0, 6'd42, 6'd52, 1'b1, 1'b1, 32'hC000, 1'b1);
        set_alloc(1, 4'd1, 6'd43, 6'd53, 1'b0, 1'b0, 32'hC001, 1'b1);
        tick(); idle();
        n_checks++;
        if (count !== 5'd4) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d, required 4", count);
        end
        set_cmpl(0, 4'd14, 32'hC00E);
        set_cmpl(1, 4'd15, 32'hC00F);
        set_cmpl(2, 4'd0, 32'hC000);
        tick(); idle();
        set_cmpl(0, 4'd1, 32'hC001);
        tick(); idle();
        drain(8);
        n_checks++;
        if (head !== 4'd2 || count !== 5'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_end: got head=%0d count=%0d err=%b, required 2 0 0",
                     head, count, err);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_alloc(0, 4'(2 * k), 6'd1, 6'd2, 1'b0, 1'b0, 32'd0, 1'b0);
            set_alloc(1, 4'(2 * k + 1), 6'd1, 6'd2, 1'b0, 1'b0, 32'd0, 1'b0);
            tick(); idle();
        end
        repeat (2) tick();
        n_checks++;
        if (count !== 5'd16 || err !== 1'b0 || retire_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: got count=%0d err=%b rv0=%b, required 16 0 0",
                     count, err, retire_valid[0]);
        end
        set_alloc(0, 4'd5, 6'd7, 6'd7, 1'b0, 1'b0, 32'd0, 1'b0);
        tick(); idle();
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL full_overwrite_err: got %b, required 1", err);
        end
        repeat (3) tick();
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b, required 1", err);
        end
    endtask

    task automatic test_stray();
        do_reset();
        set_cmpl(0, 4'd7, 32'hFEED);
        tick(); idle();
        tick();
        n_checks++;
        if (err !== 1'b1 || count !== 5'd0 || head !== 4'd0 || retire_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_cmpl: got err=%b count=%0d head=%0d rv0=%b, required 1 0 0 0",
                     err, count, head, retire_valid[0]);
        end
    endtask

    task automatic test_dup_errors();
        do_reset();
        set_alloc(0, 4'd0, 6'd30, 6'd31, 1'b1, 1'b0, 32'h1111, 1'b1);
        tick(); idle();
        set_cmpl(1, 4'd0, 32'h1111);
        set_cmpl(2, 4'd0, 32'h2222);
        tick(); idle();
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL dup_cmpl_err: got %b, required 1", err);
        end
        drain(4);
        do_reset();
        set_alloc(0, 4'd0, 6'd1, 6'd11, 1'b0, 1'b0, 32'h3333, 1'b0);
        set_alloc(1, 4'd0, 6'd2, 6'd12, 1'b1, 1'b1, 32'h3333, 1'b1);
        tick(); idle();
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL dup_alloc_err: got %b, required 1", err);
        end
        set_cmpl(0, 4'd0, 32'h3333);
        tick(); idle();
        drain(4);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_alloc(0, 4'(2 * k), 6'd20, 6'd21, 1'b1, 1'b0, 32'h5555, k == 0);
            set_alloc(1, 4'(2 * k + 1), 6'd3, 6'd4, 1'b0, 1'b0, 32'd0, 1'b0);
            tick(); idle();
        end
        set_cmpl(0, 4'd0, 32'h5555);
        tick(); idle();
        set_alloc(0, 4'd0, 6'd60, 6'd61, 1'b0, 1'b1, 32'd0, 1'b0);
        tick(); idle();
        n_checks++;
        if (retire_valid[0] !== 1'b1 || err !== 1'b0 || count !== 5'd16 || head !== 4'd1) begin
            n_fail++;
            $display("FAIL same_edge_reuse: got rv0=%b err=%b count=%0d head=%0d, required 1 0 16 1",
                     retire_valid[0], err, count, head);
        end
        // Streaming: one allocate-and-complete per cycle across two head wraps.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            d = $urandom;
            set_alloc(0, 4'(k), 6'($urandom_range(63)), 6'($urandom_range(63)),
                      1'($urandom_range(1)), 1'($urandom_range(1)), d, 1'b1);
            set_cmpl(k % 3, 4'(k), d);
            tick(); idle();
        end
        drain(6);
        n_checks++;
        if (head !== 4'd8 || count !== 5'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: got head=%0d count=%0d err=%b, required 8 0 0",
                     head, count, err);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_reset_mid();
        test_out_of_order();
        test_wrap();
        test_full();
        test_stray();
        test_dup_errors();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer that sits downstream of the dispatch/issue stage. It captures up to two `rob_row_struct` entries per cycle, indexed by their `ROBNumber`, and marks entries complete from functional-unit writebacks. It retires up to two completed entries per cycle in strict `ROBNumber` order, driving register-file commit and physical-register free.

## Interface
- `DEPTH`, 16: entry count; equals 2^width of `ROBNumber`; must be a power of two.
- `NUM_FU`, 3: number of completion ports, one per functional unit.
- `i_clk` in 1: clock. All state updates on the rising edge.
- `i_rst_n` in 1: reset. Asynchronous, active-low.
- `i_rob_rows[0:1]` in `rob_row_struct`: allocation slots. A slot is acted on only when `.valid`=1. It writes entry `.ROBNumber`.
- `i_cmpl_valid[0:NUM_FU-1]` in 1: writeback strobe.
- `i_cmpl_rob[0:NUM_FU-1]` in 4: target `ROBNumber` for the writeback.
- `i_cmpl_data[0:NUM_FU-1]` in `word`: result data.
- `o_retire_valid[0:1]` out 1: retire strobe. Slot 1 is valid only if slot 0 is valid.
- `o_retire_dst[0:1]` out `p_reg`: `PRegAddrDst` of the retiring entry.
- `o_retire_data[0:1]` out `word`: stored result.
- `o_retire_regwrite[0:1]` out 1: stored `RegWrite`.
- `o_retire_memwrite[0:1]` out 1: stored `MemWrite`.
- `o_free_preg[0:1]` out `p_reg`: `OldPRegAddrDst` to release.
- `o_head` out 4: `ROBNumber` of the oldest unretired entry.
- `o_count` out 5: number of valid entries, 0..16.
- `o_err` out 1: sticky protocol-error flag.

## Operation
- **Storage:** `DEPTH` entries. Each entry holds `valid`, `complete`, `data`, `PRegAddrDst`, `OldPRegAddrDst`, `RegWrite`, `MemWrite`, `MemtoReg`.
- **Allocation:**
  - A valid slot writes the entry at `.ROBNumber`: `valid`=1, `complete`=0, fields copied.
  - Allocations may arrive in any order.
- **Completion:**
  - A completion for a `valid` entry sets `complete`=1 and stores `data`.
  - A completion for an invalid entry is ignored and sets `o_err`.
- **Retire condition:** slot 0 retires the entry at head when it is `valid && complete`. Slot 1 retires head+1 (mod 16) under the same condition, and only if slot 0 retired.
- **Retire effect:**
  - Retired entries are cleared (`valid`=0, `complete`=0).
  - Head advances by the number retired, modulo 16. 15→0 wraps with no special case.
- **Count:** `o_count` next = `o_count` + allocations − retirements.
- **Error cases** (each sets `o_err`, which holds until reset):
  - Allocation onto an entry that is already `valid`. The entry is overwritten.
  - Both allocation slots carrying the same `ROBNumber`. Slot 1 wins.
  - Two completions to the same `ROBNumber`. The lowest FU index wins the data.
- **MemtoReg:** stored but not output. It is reserved for a future load-forwarding path.

## Timing
- **Reset (async assert):**
  - All entries invalid; `o_head`=0; `o_count`=0; `o_err`=0.
  - All `o_retire_*` and `o_free_preg` outputs are 0.
  - Reset mid-operation discards all in-flight entries. No retire is emitted.
- **Registered decisions:** retire decisions use entry state as of the previous edge. All outputs are registered.
- **Latency:**
  - Completion sampled at edge N → `o_retire_valid` high after edge N+1.
  - Allocation and completion for the same entry at the same edge N → entry is valid+complete after N and retires after N+1.
- **Strobe width:** each retire strobe is high for exactly one cycle per entry. Outputs return to 0 on cycles with no retire.
- **Same-edge allocate and retire:** an entry may be allocated at the same edge the previous occupant of that index retires. Retire clears first, then allocation writes, and no error is raised.
- **Full:** `o_count`=16. The upstream stage must not allocate. If it does, this is the overwrite case above.
- **Empty:** `o_count`=0. No retire.

## Configuration
- `ROB_DUAL_RETIRE_EN`
  - **Defined:** two retire slots as described above.
  - **Undefined:**
    - Only slot 0 ever retires.
    - `o_retire_valid[1]` and all slot-1 outputs are tied to 0.
    - Head advances by at most 1 per cycle.
  - Allocation width (2) is unchanged in both builds.

## Test plan
1. **Reset:** reset, then allocate `ROBNumber` 0 (Dst=5, Old=3) and complete it with data 0xDEADBEEF at the same edge → after the next edge, `o_retire_valid[0]`=1, `o_retire_dst[0]`=5, `o_free_preg[0]`=3, `o_retire_data[0]`=0xDEADBEEF; `o_head`=1, `o_count`=0.
2. **Out-of-order completion:** allocate 0,1,2. Complete 2, then 1 → no retire. Complete 0 → next cycle retires 0 and 1 (dual build); the following cycle retires 2; `o_head`=3.
3. **Wrap:** fill entries 14,15,0,1 with head=14 and complete all → retires in order 14,15 then 0,1; `o_head`=2, `o_count`=0, `o_err`=0.
4. **Full:** allocate all 16 without completing → `o_count`=16, no retire. Re-allocate an index → `o_err`=1 and it stays 1.
5. **Stray completion:** complete `ROBNumber` 7 while invalid → entry unchanged, `o_err`=1, no retire.
6. **Single-retire build:** `ROB_DUAL_RETIRE_EN` undefined, two completed entries at head → retire on consecutive cycles via slot 0 only; `o_retire_valid[1]` is never 1.
